pseudo_random_generator: RTL and testbench
==========================================

PSEUDO_RANDOM_GENERATOR -- requirements
Module: pseudo_random_generator

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width; legal values 8, 16, 24, 32.
REQ-002 Parameter OUT_W, default 8: output width; 1 <= OUT_W <= WIDTH.
REQ-003 Parameter SEED, default 16'hACE1 (zero-extended to WIDTH): state loaded on reset; must be nonzero.
REQ-004 Parameter STEPS, default 1: LFSR steps advanced per clock; legal range 1..8.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 arst_n  input  1  reset, asynchronous, active-low.
REQ-007 o_prng  output  OUT_W  pseudo-random value, equal to state[OUT_W-1:0].

Function
REQ-008 Internal state SHALL be a WIDTH-bit right-shifting Galois LFSR.
REQ-009 One step SHALL be: lsb = state[0]; state = state >> 1; if lsb, state ^= TAP_MASK(WIDTH).
REQ-010 TAP_MASK SHALL be 8'hB8 (WIDTH 8), 16'hB400 (16), 24'hE10000 (24), 32'h80200003 (32), giving maximal period 2^WIDTH-1.
REQ-011 Every rising clk edge with arst_n high SHALL apply exactly STEPS steps in one cycle, combinationally chained.
REQ-012 The generator SHALL be free-running: no enable or pause input; it advances every cycle.
REQ-013 o_prng SHALL be driven directly from the state register, with no combinational path from any input.
REQ-014 Latency: a new value SHALL appear on o_prng one clock edge after each step.
REQ-015 The sequence SHALL wrap after 2^WIDTH-1 steps (STEPS=1) back to SEED.

Reset
REQ-016 While arst_n is low, state SHALL be SEED and o_prng SHALL be SEED[OUT_W-1:0]; with defaults this is 8'hE1.
REQ-017 Assertion of arst_n SHALL take effect immediately without a clock edge, including in the middle of a sequence.
REQ-018 Reset release SHALL be followed by normal stepping from the first rising edge at which arst_n is high.

Configuration
REQ-019 Macro PRNG_LOCKUP_GUARD_EN, when defined, SHALL add lockup recovery: if state is all-zero at a clock edge, the next state SHALL be SEED instead of a stepped value.
REQ-020 With PRNG_LOCKUP_GUARD_EN undefined, the all-zero state SHALL persist, since zero steps to zero, and no guard logic SHALL be generated.

Structure
REQ-021 Package prng_pkg SHALL hold the TAP_MASK lookup function, the supported-width constants and the default SEED.
REQ-022 Sub-module prng_lfsr_step (combinational, WIDTH and TAP_MASK parameters) SHALL implement one step; the top instantiates STEPS copies in a chain.
REQ-023 Elaboration SHALL fail for an illegal WIDTH, OUT_W > WIDTH, SEED == 0, or STEPS outside 1..8.

Verification
REQ-024 Defaults, reset low -> o_prng = 8'hE1; release, then 6 edges -> o_prng = 70, 38, 9C, 4E, 27, 13 (hex).
REQ-025 Defaults, internal state traced -> E270, 7138, 389C, 1C4E, 0E27, B313; returns to ACE1 exactly after 65535 edges and no earlier.
REQ-026 Reset asserted asynchronously mid-run (between edges) -> o_prng = 8'hE1 before the next edge; sequence restarts per REQ-024.
REQ-027 STEPS=2, defaults otherwise -> after first edge state = 16'h7138 and o_prng = 8'h38.
REQ-028 Macro defined, state forced to 0 -> next edge state = 16'hACE1; macro undefined, same force -> state stays 0.
REQ-029 WIDTH=8, SEED=8'h01, OUT_W=8 -> period 255 and every nonzero value seen once per period.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared constants for the pseudo-random generator: supported LFSR widths,
// default seed and the maximal-length Galois tap mask for each width.
package prng_pkg;

   localparam int WIDTH_8  = 8;
   localparam int WIDTH_16 = 16;
   localparam int WIDTH_24 = 24;
   localparam int WIDTH_32 = 32;

   localparam int MIN_STEPS = 1;
   localparam int MAX_STEPS = 8;

   localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

   function automatic bit is_legal_width(input int width);
      return (width == WIDTH_8) || (width == WIDTH_16) ||
             (width == WIDTH_24) || (width == WIDTH_32);
   endfunction

   // Right-shifting Galois masks; each gives a period of 2^width-1.
   function automatic logic [31:0] tap_mask(input int width);
      logic [31:0] mask;
      mask = 32'h0;
      case (width)
         WIDTH_8:  mask = 32'h0000_00B8;
         WIDTH_16: mask = 32'h0000_B400;
         WIDTH_24: mask = 32'h00E1_0000;
         WIDTH_32: mask = 32'h8020_0003;
         default:  mask = 32'h0;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/prng_lfsr_step.sv
// One combinational step of a right-shifting Galois LFSR.
module prng_lfsr_step #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] TAP_MASK = 16'hB400
) (
   input  logic [WIDTH-1:0] cur_state,
   output logic [WIDTH-1:0] next_state
);

   assign next_state = (cur_state >> 1) ^ (cur_state[0] ? TAP_MASK : '0);

endmodule

// File: rtl/pseudo_random_generator.sv
// Free-running Galois LFSR generator advancing STEPS steps per clock.
// Optional macro PRNG_LOCKUP_GUARD_EN reloads SEED if the state reaches zero.
module pseudo_random_generator
   import prng_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter int               OUT_W = 8,
   parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED[WIDTH-1:0],
   parameter int               STEPS = 1
) (
   input  logic             clk,
   input  logic             arst_n,
   output logic [OUT_W-1:0] o_prng
);

   localparam logic [31:0]      TAP_FULL = tap_mask(WIDTH);
   localparam logic [WIDTH-1:0] TAP      = TAP_FULL[WIDTH-1:0];

   if (!is_legal_width(WIDTH)) begin : g_bad_width
      $error("pseudo_random_generator: WIDTH must be 8, 16, 24 or 32");
   end
   if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
      $error("pseudo_random_generator: OUT_W must be in 1..WIDTH");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("pseudo_random_generator: SEED must be nonzero");
   end
   if (STEPS < MIN_STEPS || STEPS > MAX_STEPS) begin : g_bad_steps
      $error("pseudo_random_generator: STEPS must be in 1..8");
   end

   logic [WIDTH-1:0]            state;
   logic [WIDTH-1:0]            state_next;
   logic [STEPS:0][WIDTH-1:0]   chain;

   assign chain[0] = state;

   for (genvar i = 0; i < STEPS; i++) begin : g_step
      prng_lfsr_step #(
         .WIDTH    (WIDTH),
         .TAP_MASK (TAP)
      ) u_step (
         .cur_state  (chain[i]),
         .next_state (chain[i+1])
      );
   end

`ifdef PRNG_LOCKUP_GUARD_EN
   // Zero is a fixed point of the LFSR, so recover by reloading the seed.
   always_comb begin
      state_next = chain[STEPS];
      if (state == '0) begin
         state_next = SEED;
      end
   end
`else
   always_comb begin
      state_next = chain[STEPS];
   end
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= SEED;
      end else begin
         state <= state_next;
      end
   end

   assign o_prng = state[OUT_W-1:0];

endmodule

// File: tb/tb_pseudo_random_generator.sv
// Scoreboard bench for pseudo_random_generator: default, STEPS=2 and 8-bit builds.
module tb_pseudo_random_generator;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp_out;
      logic [31:0] exp_state;
   } sb_item_t;

   logic       clk;
   logic       arst_n;
   logic [7:0] prng_main;
   logic [7:0] prng_two;
   logic [7:0] prng_byte;

   int checks = 0;
   int errors = 0;

   sb_item_t sb[$];

   pseudo_random_generator dut (
      .clk    (clk),
      .arst_n (arst_n),
      .o_prng (prng_main)
   );

   pseudo_random_generator #(.STEPS(2)) dut2 (
      .clk    (clk),
      .arst_n (arst_n),
      .o_prng (prng_two)
   );

   pseudo_random_generator #(.WIDTH(8), .OUT_W(8), .SEED(8'h01)) dut8 (
      .clk    (clk),
      .arst_n (arst_n),
      .o_prng (prng_byte)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: run did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push(input string name, input int sel, input logic [31:0] o, input logic [31:0] s);
      sb_item_t it;
      it.name      = name;
      it.sel       = sel;
      it.exp_out   = o;
      it.exp_state = s;
      sb.push_back(it);
   endtask

   // Monitor: compares every queued expectation at the falling edge.
   initial begin
      sb_item_t it;
      logic [31:0] act_out;
      logic [31:0] act_state;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            it = sb.pop_front();
            if (it.sel == 1) begin
               act_out   = 32'(prng_two);
               act_state = 32'(dut2.state);
            end else begin
               act_out   = 32'(prng_main);
               act_state = 32'(dut.state);
            end
            checks++;
            if (act_out !== it.exp_out || act_state !== it.exp_state) begin
               errors++;
               $display("[TB] FAIL %s: actual out=%h state=%h required out=%h state=%h",
                        it.name, act_out, act_state, it.exp_out, it.exp_state);
            end
         end
      end
   end

   task automatic applyStimulus(input string tag);
      logic [15:0] exp_state [6];
      exp_state = '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         push($sformatf("%s_edge%0d", tag, i + 1), 0, 32'(exp_state[i][7:0]), 32'(exp_state[i]));
         if (i == 0) begin
            push($sformatf("%s_steps2", tag), 1, 32'h38, 32'h7138);
         end
      end
   endtask

   initial begin
      bit [7:0] seen [256];
      int p8;
      int p16;
      int distinct;
      int zero_hits;

      arst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      push("reset_low", 0, 32'hE1, 32'hACE1);
      @(negedge clk);
      #1 arst_n = 1'b1;
      applyStimulus("run1");

      // Asynchronous reset between edges must show the seed before the next edge.
      @(posedge clk);
      #2 arst_n = 1'b0;
      #1 push("async_reset", 0, 32'hE1, 32'hACE1);
      @(negedge clk);
      #1 arst_n = 1'b1;
      applyStimulus("run2");

      @(negedge clk);
      #1 arst_n = 1'b0;
      for (int v = 0; v < 256; v++) seen[v] = 8'd0;
      p8 = 0;
      p16 = 0;
      zero_hits = 0;
      @(negedge clk);
      #1 arst_n = 1'b1;
      for (int n = 1; n <= 70000; n++) begin
         @(posedge clk);
         #1;
         if (n <= 255) begin
            if (dut8.state == 8'h00) zero_hits++;
            seen[dut8.state] = seen[dut8.state] + 8'd1;
         end
         if (p8 == 0 && dut8.state == 8'h01) p8 = n;
         if (dut.state == 16'hACE1) begin
            p16 = n;
            break;
         end
      end
      distinct = 0;
      for (int v = 1; v < 256; v++) begin
         if (seen[v] == 8'd1) distinct++;
      end
      check_value("period16", 32'(p16), 32'd65535);
      check_value("period8", 32'(p8), 32'd255);
      check_value("distinct8", 32'(distinct + zero_hits * 1000), 32'd255);

      @(negedge clk);
      force dut.state = 16'h0000;
      #1 release dut.state;
      @(posedge clk);
      #1;
`ifdef PRNG_LOCKUP_GUARD_EN
      push("lockup_edge1", 0, 32'hE1, 32'hACE1);
`else
      push("lockup_edge1", 0, 32'h00, 32'h0000);
`endif
      @(posedge clk);
      #1;
`ifdef PRNG_LOCKUP_GUARD_EN
      push("lockup_edge2", 0, 32'h70, 32'hE270);
`else
      push("lockup_edge2", 0, 32'h00, 32'h0000);
`endif
      repeat (2) @(negedge clk);
      #1;
      checkOutput();
   end

   task automatic checkOutput();
      check_value("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

endmodule
